// File: rtl/fake_mix_pipe.sv
// rtl/fake_mix_pipe.sv - pipelined majority/XNOR response generator with optional MISR (FAKE_MIX_MISR_EN)
module fake_mix_pipe #(
  parameter int               N_IN  = 10,
  parameter int               SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY  = 8'h1D,
  parameter logic [SIG_W-1:0] SEED  = '0,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_y,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             sig_clr,
  output logic [SIG_W-1:0] sig_out,
  output logic [CNT_W-1:0] res_cnt
);

  localparam int             PW  = $clog2(N_IN);
  localparam logic [PW:0]    THR = (PW+1)'(N_IN - 1);

  logic [N_IN-1:0] d1;
  logic            v1, v2, v3;
  logic            maj2, top2;
  logic            y3;
  logic            adv;
  logic [PW-1:0]   pcnt;
  logic            maj;

  // A single global stall: everything moves unless the output slot is full and blocked
  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign out_y     = y3;

  // Popcount of the low N_IN-1 bits and strict-majority compare (ties lose)
  always_comb begin
    pcnt = '0;
    for (int i = 0; i < N_IN - 1; i++) begin
      pcnt = pcnt + {{(PW-1){1'b0}}, d1[i]};
    end
    maj = ({pcnt, 1'b0} > THR);
  end

  // Three-stage pipeline; bubbles carry y=0 so out_y is 0 whenever out_valid is 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1   <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      maj2 <= 1'b0;
      top2 <= 1'b0;
      y3   <= 1'b0;
    end else if (adv) begin
      d1   <= in_vec;
      v1   <= in_valid && in_ready;
      maj2 <= maj;
      top2 <= d1[N_IN-1];
      v2   <= v1;
      y3   <= v2 & ~(maj2 ^ top2);
      v3   <= v2;
    end
  end

`ifdef FAKE_MIX_MISR_EN
  logic             acc;
  logic [SIG_W-1:0] sig;
  logic [CNT_W-1:0] cnt;
  logic [SIG_W-1:0] sig_next;

  assign acc     = v3 && out_ready;
  assign sig_out = sig;
  assign res_cnt = cnt;

  // Next MISR state: shift, fold polynomial on carry-out, inject the result bit
  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0)
             ^ {{(SIG_W-1){1'b0}}, y3};
  end

  // Signature and saturating result counter; clear wins over a same-cycle accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= SEED;
      cnt <= '0;
    end else if (sig_clr) begin
      sig <= SEED;
      cnt <= '0;
    end else if (acc) begin
      sig <= sig_next;
      if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  logic unused_sig_clr;

  assign unused_sig_clr = sig_clr;
  assign sig_out        = SEED;
  assign res_cnt        = '0;
`endif

endmodule

// File: doc/fake_mix_pipe.md
# fake_mix_pipe

Parametrised, pipelined successor to the flat single-output majority/XNOR netlists in the fake-netlist set. It accepts an N_IN-bit input vector per handshake and computes one response bit: XNOR of a majority vote over the low N_IN-1 bits with the top bit. Results are delivered through a backpressured valid/ready stream and, optionally, compressed into a MISR signature. It sits between a stimulus source and a checker, so netlist-style logic can be exercised at streaming rate.

## Interface
- N_IN, 10, input vector width (≥3)
- SIG_W, 8, MISR signature width (≥2)
- POLY, 8'h1D, MISR feedback polynomial (SIG_W bits)
- SEED, 0, MISR value after reset or clear
- CNT_W, 16, result counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_vec  in  N_IN  input vector
- in_valid  in  1  in_vec valid
- in_ready  out  1  block can accept
- out_y  out  1  response bit
- out_valid  out  1  out_y valid
- out_ready  in  1  consumer accepts
- sig_clr  in  1  synchronous MISR/counter clear
- sig_out  out  SIG_W  current signature
- res_cnt  out  CNT_W  accepted results, saturating

## Operation
- Function: p = popcount(in_vec[N_IN-2:0]); maj = (2·p > N_IN-1); y = ~(maj ^ in_vec[N_IN-1]). Ties (even N_IN-1, p exactly half) give maj=0.
- popcount width is clog2(N_IN); compare is unsigned.
- Three-stage pipeline:
  - S1 registers in_vec.
  - S2 registers maj and top bit.
  - S3 registers y into out_y.
  - Each stage has a valid flag v1/v2/v3; out_valid = v3.
- Global stall: adv = !v3 || out_ready. in_ready = adv, which is combinational from out_ready and v3.
- When adv=1, all stages shift and S1 captures in_vec; v1 takes in_valid && in_ready. When adv=0, all stages hold.
- Bubbles propagate as invalid slots; data in invalid slots is don't-care, but out_y must be 0 when out_valid=0.
- Result accept: acc = out_valid && out_ready.
- On acc:
  - sig ← (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ {0…, out_y}
  - res_cnt ← res_cnt+1, holding at 2^CNT_W-1 (no wrap)
- sig_clr=1: sig ← SEED, res_cnt ← 0.
  - Clear has priority over a simultaneous acc: the result is not folded in and not counted.
  - Clear does not touch the pipeline.
- Reset mid-stream discards all in-flight vectors; no partial output.

## Timing
- Reset values: in_ready=1 (v3=0), out_valid=0, out_y=0, sig_out=SEED, res_cnt=0; v1=v2=v3=0.
- Latency: with out_ready held 1, a vector accepted at edge k appears with out_valid=1 after edge k+2 and can be accepted at edge k+3.
- Throughput: one result per cycle under continuous valid/ready.
- Backpressure: if out_ready=0 while out_valid=1, out_y/out_valid hold stable and in_ready=0 in the same cycle.
- sig_out/res_cnt are registered and reflect an acc one cycle after its edge.
- in_valid may drop without a transfer; no ordering or retention requirement on the producer.

## Configuration
- FAKE_MIX_MISR_EN defined: MISR and res_cnt behave as above.
- Not defined:
  - MISR and counter logic is removed.
  - sig_out is tied to SEED and res_cnt is tied to 0.
  - sig_clr is ignored.
  - The pipeline and handshake are unchanged.

## Test plan
- Defaults, reset then out_ready=1; drive 10'h3FF, 10'h000, 10'h01F, 10'h00F on consecutive cycles → out_y = 1,1,0,1 on four consecutive out_valid cycles, first appearing two cycles after the first accept.
- Same sequence with MISR enabled, SEED=0 → sig_out after each acc: 8'h01, 8'h03, 8'h06, 8'h0D; res_cnt=4.
- Hold out_ready=0 for 5 cycles with in_valid=1 → at most 3 vectors accepted, in_ready=0 while v3=1, out_y stable; release → remaining results in order, no loss or duplication.
- sig=8'h80, acc with y=0 → sig=8'h1D. sig_clr asserted in the same cycle as an acc → sig=SEED, res_cnt=0.
- CNT_W=2: accept 5 results → res_cnt=3 (saturated). Assert rst_n=0 with 2 vectors in flight → next cycle out_valid=0, sig_out=SEED, in_ready=1.
- Build without FAKE_MIX_MISR_EN → streaming results identical to the first scenario; sig_out constant SEED, res_cnt constant 0.
